// File: rtl/snake_pkg.sv
// snake_pkg: shared grid types, start position and move/wall helpers for the snake
package snake_pkg;

    typedef enum logic [1:0] {RIGHT, DOWN, LEFT, UP} dir_t;

    localparam int GRID_W = 20;
    localparam int GRID_H = 11;

    typedef logic [4:0] coord_x_t;
    typedef logic [3:0] coord_y_t;

    typedef struct packed {
        coord_x_t x;
        coord_y_t y;
    } cell_t;

    localparam coord_x_t START_X = 5'd10;
    localparam coord_y_t START_Y = 4'd6;
    localparam coord_x_t WALL_X  = coord_x_t'(GRID_W + 1);
    localparam coord_y_t WALL_Y  = coord_y_t'(GRID_H + 1);

    // Neighbouring cell one step in direction d; y grows downwards.
    function automatic cell_t step_cell(cell_t c, dir_t d);
        cell_t n;
        n = c;
        n.x = (d == RIGHT) ? c.x + 5'd1 : (d == LEFT) ? c.x - 5'd1 : c.x;
        n.y = (d == DOWN) ? c.y + 4'd1 : (d == UP) ? c.y - 4'd1 : c.y;
        return n;
    endfunction

    // The playfield is bordered by a one-cell wall ring.
    function automatic logic is_wall(cell_t c);
        return c.x == 5'd0 || c.x == WALL_X || c.y == 4'd0 || c.y == WALL_Y;
    endfunction

endpackage

// File: rtl/snake_ring.sv
// snake_ring: ring buffer of snake cells, one sync write port and one comb read port
module snake_ring
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int AW       = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [8:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [8:0]    rdata
);

    logic [8:0] mem [MAX_LEN];

    // Reset lays the body out leftwards from the start cell, tail at slot 0, head at INIT_LEN-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++)
                mem[i] <= (i < INIT_LEN) ? {START_X - 5'(INIT_LEN - 1 - i), START_Y} : 9'd0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/snake_body.sv
// snake_body: moves the snake one cell per step and streams its segments head to tail
module snake_body
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_step,
    input  logic [1:0] i_dir,
    input  logic       i_eat,
    output logic [4:0] o_snake_x,
    output logic [3:0] o_snake_y,
    output logic       o_snake_first,
    output logic       o_snake_last,
    output logic       o_snake_valid,
    output logic       o_busy,
    output logic [5:0] o_length,
    output logic       o_dead
);

    localparam int AW = $clog2(MAX_LEN);

    typedef enum logic [1:0] {IDLE, MOVE, STREAM, DEAD} state_t;

    state_t        state;
    dir_t          dir;
    cell_t         head;
    cell_t         nxt;
    cell_t         rd_cell;
    logic [AW-1:0] head_ptr;
    logic [AW-1:0] tail_ptr;
    logic [AW-1:0] rd_ptr;
    logic [8:0]    rd_data;
    logic          grow_pending;
    logic          lead;
    logic          hit;
    logic          wall;
    logic          match;
    logic          is_last;
    logic          we;

    assign nxt     = step_cell(head, dir);
    assign wall    = is_wall(nxt);
    assign we      = state == MOVE && !wall;
    assign rd_cell = cell_t'(rd_data);
    assign match   = !lead && rd_cell == head;
    assign is_last = rd_ptr == tail_ptr;

    snake_ring #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .AW(AW)) u_ring (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (head_ptr + AW'(1)),
        .wdata (nxt),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Game FSM: latch a step, move the head, stream head-to-tail, then settle in IDLE or DEAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dir           <= RIGHT;
            head          <= {START_X, START_Y};
            head_ptr      <= AW'(INIT_LEN - 1);
            tail_ptr      <= '0;
            rd_ptr        <= '0;
            grow_pending  <= 1'b0;
            lead          <= 1'b0;
            hit           <= 1'b0;
            o_length      <= 6'(INIT_LEN);
            o_dead        <= 1'b0;
            o_busy        <= 1'b0;
            o_snake_x     <= '0;
            o_snake_y     <= '0;
            o_snake_first <= 1'b0;
            o_snake_last  <= 1'b0;
            o_snake_valid <= 1'b0;
        end else begin
            o_snake_x     <= '0;
            o_snake_y     <= '0;
            o_snake_first <= 1'b0;
            o_snake_last  <= 1'b0;
            o_snake_valid <= 1'b0;
            if (i_eat && state != DEAD && o_length < 6'(MAX_LEN))
                grow_pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (i_step) begin
                        state  <= MOVE;
                        o_busy <= 1'b1;
                        if (i_dir != (dir ^ 2'd2))
                            dir <= dir_t'(i_dir);
                    end
                end
                MOVE: begin
                    if (wall) begin
                        state  <= DEAD;
                        o_dead <= 1'b1;
                    end else begin
                        state        <= STREAM;
                        head         <= nxt;
                        head_ptr     <= head_ptr + AW'(1);
                        rd_ptr       <= head_ptr + AW'(1);
                        lead         <= 1'b1;
                        hit          <= 1'b0;
                        grow_pending <= 1'b0;
                        if (grow_pending && o_length < 6'(MAX_LEN))
                            o_length <= o_length + 6'd1;
                        else
                            tail_ptr <= tail_ptr + AW'(1);
                    end
                end
                STREAM: begin
                    o_snake_valid <= 1'b1;
                    o_snake_x     <= rd_cell.x;
                    o_snake_y     <= rd_cell.y;
                    o_snake_first <= lead;
                    o_snake_last  <= is_last;
                    lead          <= 1'b0;
                    rd_ptr        <= rd_ptr - AW'(1);
                    hit           <= hit | match;
                    if (is_last) begin
                        state  <= (hit | match) ? DEAD : IDLE;
                        o_busy <= hit | match;
                    end
                end
                DEAD: o_dead <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: scoreboard bench driving directed moves against a reference snake model
module tb_snake_body;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_step;
    logic [1:0] i_dir;
    logic       i_eat;
    logic [4:0] o_snake_x;
    logic [3:0] o_snake_y;
    logic       o_snake_first;
    logic       o_snake_last;
    logic       o_snake_valid;
    logic       o_busy;
    logic [5:0] o_length;
    logic       o_dead;

    typedef struct {int x; int y; bit f; bit l;} exp_t;

    exp_t sb[$];
    int   bx[$];
    int   by[$];
    int   mdir;
    bit   mgrow;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    snake_body dut (
        .clk           (clk),
        .rst           (rst),
        .i_step        (i_step),
        .i_dir         (i_dir),
        .i_eat         (i_eat),
        .o_snake_x     (o_snake_x),
        .o_snake_y     (o_snake_y),
        .o_snake_first (o_snake_first),
        .o_snake_last  (o_snake_last),
        .o_snake_valid (o_snake_valid),
        .o_busy        (o_busy),
        .o_length      (o_length),
        .o_dead        (o_dead)
    );

    // Pops one expected beat per valid output beat.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (o_snake_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected got (%0d,%0d) f=%0d l=%0d, none expected",
                         o_snake_x, o_snake_y, o_snake_first, o_snake_last);
            end else begin
                e = sb.pop_front();
                if (o_snake_x != 5'(e.x) || o_snake_y != 4'(e.y) ||
                    o_snake_first != e.f || o_snake_last != e.l) begin
                    errors++;
                    $display("FAIL beat got (%0d,%0d) f=%0d l=%0d want (%0d,%0d) f=%0d l=%0d",
                             o_snake_x, o_snake_y, o_snake_first, o_snake_last,
                             e.x, e.y, e.f, e.l);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((o_busy || o_snake_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 1, 0);
    endtask

    task automatic wait_first();
        int n = 0;
        while (!o_snake_first && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("first_timeout", 1, 0);
    endtask

    task automatic model_reset();
        bx = '{10, 9, 8};
        by = '{6, 6, 6};
        mdir = 0;
        mgrow = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_step = 1'b0;
        i_eat = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic eat_now();
        @(negedge clk);
        i_eat = 1'b1;
        @(negedge clk);
        i_eat = 1'b0;
        if (bx.size() < 32) mgrow = 1'b1;
    endtask

    // One move: updates the model, queues the expected stream, optionally eats or re-steps mid-stream.
    task automatic step(input int d, input bit eat_first, input bit dup);
        int nx, ny;
        bit hit;
        wait_idle();
        if (d != (mdir ^ 2)) mdir = d;
        nx = bx[0] + int'(mdir == 0) - int'(mdir == 2);
        ny = by[0] + int'(mdir == 1) - int'(mdir == 3);
        @(negedge clk);
        i_step = 1'b1;
        i_dir = 2'(d);
        if (nx >= 1 && nx <= 20 && ny >= 1 && ny <= 11) begin
            bx.push_front(nx);
            by.push_front(ny);
            if (!(mgrow && bx.size() <= 32)) begin
                void'(bx.pop_back());
                void'(by.pop_back());
            end
            mgrow = 1'b0;
            hit = 1'b0;
            for (int i = 1; i < bx.size(); i++)
                if (bx[i] == nx && by[i] == ny) hit = 1'b1;
            for (int i = 0; i < bx.size(); i++)
                sb.push_back('{bx[i], by[i], i == 0, i == bx.size() - 1});
        end
        @(negedge clk);
        i_step = 1'b0;
        if (eat_first || dup) begin
            wait_first();
            i_eat = eat_first;
            i_step = dup;
            @(negedge clk);
            i_eat = 1'b0;
            i_step = 1'b0;
            if (eat_first && bx.size() < 32) mgrow = 1'b1;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        i_step = 1'b0;
        i_dir = 2'd0;
        i_eat = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", int'(o_snake_valid), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_dead", int'(o_dead), 0);
        check("rst_length", int'(o_length), 3);
        rst = 1'b0;
        model_reset();

        // basic move right, eating during its first beat; then growth keeps tail (9,6)
        step(0, 1'b1, 1'b0);
        wait_idle();
        check("len_after_first", int'(o_length), 3);
        step(0, 1'b0, 1'b0);
        wait_idle();
        check("len_after_grow", int'(o_length), 4);

        // reversal ignored; extra step during stream dropped
        step(2, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1);
        wait_idle();
        repeat (4) @(negedge clk);
        check("no_extra_stream", sb.size(), 0);
        check("len_after_rev", int'(o_length), 4);

        // self collision: grow to 5, then down, left, up onto the body
        step(0, 1'b1, 1'b0);
        step(1, 1'b0, 1'b0);
        wait_idle();
        check("len_five", int'(o_length), 5);
        step(2, 1'b0, 1'b0);
        wait_idle();
        check("alive_before_hit", int'(o_dead), 0);
        step(3, 1'b0, 1'b0);
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("self_dead", int'(o_dead), 1);
        check("self_dead_valid", int'(o_snake_valid), 0);
        check("self_dead_busy", int'(o_busy), 1);

        // wall collision after walking to x=20
        do_reset();
        for (int i = 0; i < 10; i++) step(0, 1'b0, 1'b0);
        wait_idle();
        @(negedge clk);
        i_step = 1'b1;
        i_dir = 2'd0;
        @(negedge clk);
        i_step = 1'b0;
        check("wall_dead_early", int'(o_dead), 0);
        @(negedge clk);
        check("wall_dead", int'(o_dead), 1);
        @(negedge clk);
        i_step = 1'b1;
        @(negedge clk);
        i_step = 1'b0;
        repeat (5) @(negedge clk);
        check("dead_sticky", int'(o_dead), 1);
        check("dead_busy", int'(o_busy), 1);
        check("dead_len", int'(o_length), 3);

        // pointer wrap: 36 moves round a square without eating
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int d = 0; d < 4; d++)
                for (int k = 0; k < 3; k++) step(d, 1'b0, 1'b0);
        wait_idle();
        check("wrap_len", int'(o_length), 3);
        check("wrap_alive", int'(o_dead), 0);

        // fill to 32 and keep eating: length saturates
        do_reset();
        eat_now();
        for (int i = 0; i < 10; i++) step(0, 1'b1, 1'b0);
        step(1, 1'b1, 1'b0);
        for (int i = 0; i < 19; i++) step(2, 1'b1, 1'b0);
        step(3, 1'b1, 1'b0);
        wait_idle();
        check("full_len", int'(o_length), 32);
        check("full_alive", int'(o_dead), 0);

        // reset mid-stream aborts and restores the initial body
        step(3, 1'b0, 1'b0);
        wait_first();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort_valid", int'(o_snake_valid), 0);
        check("rst_abort_len", int'(o_length), 3);
        check("rst_abort_busy", int'(o_busy), 0);
        rst = 1'b0;
        model_reset();
        step(0, 1'b0, 1'b0);
        wait_idle();
        repeat (2) @(negedge clk);
        check("drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
